// File: rtl/version_streamer.sv
// version_pkg holds the build identification streamed by version_streamer.
// version_streamer emits a 13-byte version frame: a header, the version and
// build timestamp from version_pkg, then an XOR checksum. A frame starts on
// a request or on auto-timer expiry, and it honours tx_ready backpressure.
package version_pkg;
    localparam logic [7:0]  C_VERSION_MAJOR  = 8'd1;
    localparam logic [7:0]  C_VERSION_MINOR  = 8'd2;
    localparam logic [7:0]  C_VERSION_PATCH  = 8'd3;
    localparam logic [7:0]  C_VERSION_BUILD  = 8'd68;
    localparam logic [15:0] C_VERSION_YEAR   = 16'h2025;
    localparam logic [7:0]  C_VERSION_MONTH  = 8'h11;
    localparam logic [7:0]  C_VERSION_DAY    = 8'h11;
    localparam logic [7:0]  C_VERSION_HOUR   = 8'h09;
    localparam logic [7:0]  C_VERSION_MINUTE = 8'h23;
    localparam logic [7:0]  C_VERSION_SECOND = 8'h21;
endpackage

module version_streamer
    import version_pkg::*;
#(
    parameter logic [7:0]  HEADER_BYTE = 8'hA5,
    parameter int unsigned AUTO_PERIOD = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_last,
    output logic        busy,
    output logic [15:0] frame_count
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [3:0]  LAST_IDX = 4'd12;
    localparam logic [31:0] RELOAD   = 32'(AUTO_PERIOD - 32'd1);

    // Bytes 0..11 of the frame; everything after these is the checksum.
    function automatic logic [7:0] payload_byte(input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = HEADER_BYTE;
            4'd1:    b = C_VERSION_MAJOR;
            4'd2:    b = C_VERSION_MINOR;
            4'd3:    b = C_VERSION_PATCH;
            4'd4:    b = C_VERSION_BUILD;
            4'd5:    b = C_VERSION_YEAR[15:8];
            4'd6:    b = C_VERSION_YEAR[7:0];
            4'd7:    b = C_VERSION_MONTH;
            4'd8:    b = C_VERSION_DAY;
            4'd9:    b = C_VERSION_HOUR;
            4'd10:   b = C_VERSION_MINUTE;
            4'd11:   b = C_VERSION_SECOND;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // XOR of bytes 0..11; all inputs are constants, so this folds to a constant.
    function automatic logic [7:0] frame_checksum();
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 12; i++) begin
            acc = acc ^ payload_byte(4'(i));
        end
        return acc;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [3:0] idx);
        logic [7:0] b;
        if (idx == LAST_IDX) begin
            b = frame_checksum();
        end else begin
            b = payload_byte(idx);
        end
        return b;
    endfunction

    state_t      state_r, state_n;
    logic [3:0]  idx_r, idx_n;
    logic        pending_r, pending_n;
    logic [7:0]  data_r, data_n;
    logic        last_r, last_n;
    logic [15:0] count_r, count_n;
    logic [31:0] timer_r;
    logic        expire_s;
    logic        accept_s;
    logic        start_s;

    assign expire_s = (AUTO_PERIOD != 32'd0) && (timer_r == 32'd0);
    assign accept_s = (state_r == SEND) && tx_ready;
    assign start_s  = (state_r == IDLE) && (req_i || expire_s || pending_r);

    // Free-running auto-send down-counter, independent of the frame FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r <= RELOAD;
        end else if (timer_r == 32'd0) begin
            timer_r <= RELOAD;
        end else begin
            timer_r <= timer_r - 32'd1;
        end
    end

    // Next-state, byte index, pending flag and output byte selection.
    always_comb begin
        state_n   = state_r;
        idx_n     = idx_r;
        pending_n = pending_r;
        data_n    = data_r;
        last_n    = last_r;
        count_n   = count_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_n   = SEND;
                    idx_n     = 4'd0;
                    pending_n = 1'b0;
                    data_n    = frame_byte(4'd0);
                    last_n    = 1'b0;
                end else begin
                    state_n   = IDLE;
                end
            end
            SEND: begin
                // Events during a frame (including the final-byte cycle) merge into one flag.
                pending_n = pending_r | req_i | expire_s;
                if (accept_s) begin
                    if (idx_r == LAST_IDX) begin
                        state_n = IDLE;
                        idx_n   = 4'd0;
                        data_n  = 8'h00;
                        last_n  = 1'b0;
                        count_n = count_r + 16'd1;
                    end else begin
                        idx_n  = idx_r + 4'd1;
                        data_n = frame_byte(idx_r + 4'd1);
                        last_n = (idx_r == (LAST_IDX - 4'd1));
                    end
                end else begin
                    state_n = SEND;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            idx_r     <= 4'd0;
            pending_r <= 1'b0;
            data_r    <= 8'h00;
            last_r    <= 1'b0;
            count_r   <= 16'd0;
        end else begin
            state_r   <= state_n;
            idx_r     <= idx_n;
            pending_r <= pending_n;
            data_r    <= data_n;
            last_r    <= last_n;
            count_r   <= count_n;
        end
    end

    assign tx_valid    = (state_r == SEND);
    assign busy        = (state_r == SEND);
    assign tx_data     = data_r;
    assign tx_last     = last_r;
    assign frame_count = count_r;

endmodule

// File: tb/tb_version_streamer.sv
// Directed bench for version_streamer: basic frame, backpressure, merged and
// last-cycle requests, reset mid-frame, count wrap and auto-send.
module tb_version_streamer;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        busy;
    logic [15:0] frame_count;

    logic        rst_a;
    logic [7:0]  a_data;
    logic        a_valid;
    logic        a_last;
    logic        a_busy;
    logic [15:0] a_count;

    int          checks;
    int          fails;
    logic [15:0] exp_count;
    logic [7:0]  exp_bytes [13];

    version_streamer dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_last     (tx_last),
        .busy        (busy),
        .frame_count (frame_count)
    );

    version_streamer #(.AUTO_PERIOD(32'd40)) dut_auto (
        .clk         (clk),
        .rst         (rst_a),
        .req_i       (1'b0),
        .tx_ready    (1'b1),
        .tx_data     (a_data),
        .tx_valid    (a_valid),
        .tx_last     (a_last),
        .busy        (a_busy),
        .frame_count (a_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame();
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
    endtask

    // Walks a frame whose byte 0 is on the outputs now. Optionally stalls at
    // stall_idx for stall_len cycles and pulses req_i at bytes in req_mask.
    task automatic send_frame(input int stall_idx, input int stall_len, input logic [12:0] req_mask);
        for (int i = 0; i < 13; i++) begin
            if (i == stall_idx) begin
                tx_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check($sformatf("stall%0d_valid", s), 32'(tx_valid), 32'd1);
                    check($sformatf("stall%0d_data", s), 32'(tx_data), 32'(exp_bytes[i]));
                    check($sformatf("stall%0d_last", s), 32'(tx_last), 32'd0);
                    tick();
                end
                tx_ready = 1'b1;
            end
            check($sformatf("byte%0d_valid", i), 32'(tx_valid), 32'd1);
            check($sformatf("byte%0d_data", i), 32'(tx_data), 32'(exp_bytes[i]));
            check($sformatf("byte%0d_last", i), 32'(tx_last), (i == 12) ? 32'd1 : 32'd0);
            req_i = req_mask[i];
            tick();
            req_i = 1'b0;
        end
        exp_count = exp_count + 16'd1;
        check("gap_valid", 32'(tx_valid), 32'd0);
        check("gap_busy", 32'(busy), 32'd0);
        check("frame_count", 32'(frame_count), 32'(exp_count));
    endtask

    initial begin
        int         rise [3];
        int         nrise;
        int         nlast;
        logic       prev_valid;
        logic       done;

        checks   = 0;
        fails    = 0;
        exp_count = 16'd0;
        exp_bytes = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h44, 8'h20, 8'h25,
                      8'h11, 8'h11, 8'h09, 8'h23, 8'h21, 8'hEF};
        rst      = 1'b1;
        rst_a    = 1'b1;
        req_i    = 1'b0;
        tx_ready = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_last", 32'(tx_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(tx_data), 32'h00);
        check("rst_count", 32'(frame_count), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_valid", 32'(tx_valid), 32'd0);

        // Basic frame with one-cycle latency
        start_frame();
        send_frame(-1, 0, 13'h0000);
        tick();
        check("no_extra_frame", 32'(tx_valid), 32'd0);

        // Backpressure on byte 3 for 5 cycles
        start_frame();
        send_frame(3, 5, 13'h0000);
        tick();
        check("bp_no_extra", 32'(tx_valid), 32'd0);

        // Three requests during a frame merge into one follow-on frame
        start_frame();
        send_frame(-1, 0, 13'b0_0010_0010_0100);
        tick();
        check("merge_start_valid", 32'(tx_valid), 32'd1);
        send_frame(-1, 0, 13'h0000);
        tick();
        check("merge_no_third_a", 32'(tx_valid), 32'd0);
        tick();
        check("merge_no_third_b", 32'(tx_valid), 32'd0);

        // Request coinciding with final-byte acceptance becomes pending
        start_frame();
        send_frame(-1, 0, 13'b1_0000_0000_0000);
        tick();
        check("lastreq_start_valid", 32'(tx_valid), 32'd1);
        send_frame(-1, 0, 13'h0000);
        tick();
        check("lastreq_no_extra", 32'(tx_valid), 32'd0);

        // Reset during byte 6, with req_i held high through reset
        start_frame();
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        check("pre_rst_data", 32'(tx_data), 32'(exp_bytes[6]));
        rst   = 1'b1;
        req_i = 1'b1;
        tick();
        rst   = 1'b0;
        req_i = 1'b0;
        check("midrst_valid", 32'(tx_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_count", 32'(frame_count), 32'd0);
        check("midrst_data", 32'(tx_data), 32'h00);
        tick();
        check("midrst_no_resume", 32'(tx_valid), 32'd0);
        exp_count = 16'd0;
        start_frame();
        send_frame(-1, 0, 13'h0000);

        // frame_count wraps from FFFF to 0
        force dut.count_r = 16'hFFFF;
        tick();
        release dut.count_r;
        tick();
        check("preload_count", 32'(frame_count), 32'h0000FFFF);
        exp_count = 16'hFFFF;
        start_frame();
        send_frame(-1, 0, 13'h0000);

        // Auto-send every 40 cycles
        rst_a      = 1'b0;
        nrise      = 0;
        nlast      = 0;
        prev_valid = 1'b0;
        done       = 1'b0;
        for (int k = 1; k <= 300 && !done; k++) begin
            tick();
            if (a_valid && !prev_valid && nrise < 3) begin
                rise[nrise] = k;
                nrise++;
            end
            prev_valid = a_valid;
            if (a_valid && a_last) begin
                nlast++;
                if (nlast == 3) begin
                    tick();
                    check("auto_count", 32'(a_count), 32'd3);
                    done = 1'b1;
                end
            end
        end
        check("auto_done", 32'(done), 32'd1);
        check("auto_nrise", 32'(nrise), 32'd3);
        if (nrise == 3) begin
            check("auto_first", 32'(rise[0]), 32'd40);
            check("auto_period1", 32'(rise[1] - rise[0]), 32'd40);
            check("auto_period2", 32'(rise[2] - rise[1]), 32'd40);
        end else begin
            fails++;
            $display("FAIL auto_rises observed=%0d expected=3", nrise);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/version_streamer.md
VERSION_STREAMER -- requirements
Module: version_streamer

Interface
REQ-001 Parameter HEADER_BYTE, default 8'hA5: first byte of every frame.
REQ-002 Parameter AUTO_PERIOD, default 0: auto-send interval in clk cycles; 0 disables auto-send.
REQ-003 clk  input  1  sole clock; all logic on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 req_i  input  1  single-cycle frame request.
REQ-006 tx_ready  input  1  downstream byte sink accepts tx_data.
REQ-007 tx_data  output  8  frame byte.
REQ-008 tx_valid  output  1  tx_data is valid.
REQ-009 tx_last  output  1  marks the final byte of the frame.
REQ-010 busy  output  1  frame in progress.
REQ-011 frame_count  output  16  number of completed frames.

Function
REQ-012 The frame SHALL be 13 bytes, index 0..12, sent in order:
- 0: HEADER_BYTE
- 1..4: C_VERSION_MAJOR, MINOR, PATCH, BUILD
- 5..6: C_VERSION_YEAR[15:8], [7:0]
- 7..11: MONTH, DAY, HOUR, MINUTE, SECOND
- 12: checksum
All values come from version_pkg.
REQ-013 The checksum SHALL be the XOR of bytes 0..11.
REQ-014 The FSM SHALL have two states:
- IDLE -> SEND on a start event.
- SEND -> IDLE when byte 12 is accepted (tx_valid && tx_ready).
REQ-015 A start event SHALL be either req_i=1 or the auto-timer expiring, sampled in IDLE.
REQ-016 tx_valid SHALL assert in the cycle after the start event is sampled.
- Latency is 1 cycle when tx_ready is held high.
- A frame then takes 13 cycles.
REQ-017 While tx_valid=1 and tx_ready=0, tx_data, tx_last and the byte index SHALL hold stable.
REQ-018 The byte index (4 bits) SHALL advance only on an accepted byte.
REQ-019 tx_last SHALL be 1 only when tx_valid=1 and the index is 12.
REQ-020 busy SHALL equal (state==SEND).
REQ-021 tx_valid SHALL be 0 in IDLE.
REQ-022 Pending requests:
- A req_i or timer expiry during SEND SHALL set a single pending flag.
- Further events while the flag is set SHALL be merged into it.
REQ-023 After the final byte is accepted:
- The FSM SHALL spend exactly one cycle in IDLE.
- If the pending flag is set, it SHALL then start a new frame and clear the flag.
- The gap between frames is therefore exactly 1 cycle with tx_valid=0.
REQ-024 req_i arriving in the same cycle as the final-byte acceptance SHALL set the pending flag.
REQ-025 Auto-timer (AUTO_PERIOD>0):
- A free-running down-counter SHALL reload to AUTO_PERIOD-1 on reaching 0.
- Reaching 0 is an expiry event.
- The counter SHALL run regardless of FSM state.
REQ-026 frame_count SHALL increment by 1 on each final-byte acceptance and SHALL wrap from 16'hFFFF to 0.

Reset
REQ-027 While rst=1, on the clock edge, the block SHALL return to this state regardless of any frame in progress:
- state=IDLE, index=0, pending=0
- tx_valid=0, tx_last=0, busy=0, tx_data=8'h00
- frame_count=0, auto-timer=AUTO_PERIOD-1
REQ-028 A frame interrupted by reset SHALL NOT count and SHALL NOT resume.
REQ-029 req_i asserted while rst=1 SHALL be ignored.

Verification
REQ-030 Basic frame:
- Stimulus: tx_ready=1, req_i pulse at cycle N.
- Response: tx_valid in cycles N+1..N+13; bytes A5, major, minor, patch, build, 20, 25, 11, 11, 09, 23, 21, checksum.
- For package build 8'd68 / 2025-11-11 09:23:21, the checksum is 8'hEF.
- tx_last is 1 only at N+13; frame_count=1.
REQ-031 Backpressure: hold tx_ready=0 for 5 cycles on byte 3 -> tx_data stays at the PATCH value; the sequence resumes without loss or duplication.
REQ-032 Merged requests:
- Stimulus: three req_i pulses during one frame.
- Response: exactly one follow-on frame, after exactly 1 idle cycle; frame_count=2.
REQ-033 Auto-send: AUTO_PERIOD=40, tx_ready=1, no req_i -> a frame starts every 40 cycles; frame_count=3 after the third tx_last.
REQ-034 Reset mid-frame:
- Stimulus: rst=1 during byte 6.
- Response: next cycle tx_valid=0, busy=0, frame_count=0.
- A subsequent req_i produces a full frame starting with A5.
REQ-035 Wrap: preload/force frame_count=16'hFFFF, send one frame -> frame_count=0.
